dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the word-organised data memory. Serialises load/store requests from the pipeline MEM stage (port 0) and a secondary master such as a debug/DMA bridge (port 1) onto the single DM access port. Each request carries width and load-sign controls that are forwarded unchanged to the DM. Returns a registered read result with a one-cycle acknowledge.

---
 rtl/dm_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 19 +
 rtl/dm_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions between the data memory and its access arbiter:
// access width encodings, arbiter FSM states and the latched request bundle.
package dm_pkg;

  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wd;
  } dm_req_t;

  // True when the access cannot be served at this address/width.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (width)
      WORD:    bad = (lo != 2'b00);
      HALF:    bad = lo[0];
      BYTE:    bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: a lone requester always wins; a tie goes to the
// pointed-to port, or always to port 0 when FIXED_PRI is set.
module rr_arb2 #(
  parameter int FIXED_PRI = 0
) (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if ((FIXED_PRI != 0) || !ptr) gnt = 2'b01;
      else                          gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the word-organised data memory.
// Optional alignment checking is enabled by defining DM_ARB_ALIGN_CHECK_EN.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_width,
  input  logic        p0_sign,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
  output logic        p0_ack,
  output logic [31:0] p0_rd,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_width,
  input  logic        p1_sign,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  output logic        p1_ack,
  output logic [31:0] p1_rd,
  output logic        p1_err,
  output logic        dm_we,
  output logic [1:0]  dm_width,
  output logic        dm_sign,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  arb_state_e  state_q, state_d;
  logic        port_q, port_d;
  logic        ptr_q, ptr_d;
  logic        rsp_err_q, rsp_err_d;
  dm_req_t     req_q, req_d;
  logic [31:0] rsp_rd_q, rsp_rd_d;
  logic [1:0]  gnt;
  logic        err_now;

  rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_pick (
    .req ({p1_req, p0_req}),
    .ptr (ptr_q),
    .gnt (gnt)
  );

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign err_now = misaligned(req_q.width, req_q.addr[1:0]);
`else
  assign err_now = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    ptr_d     = ptr_q;
    req_d     = req_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_err_d = rsp_err_q;
    dm_we     = 1'b0;
    dm_width  = 2'b00;
    dm_sign   = 1'b0;
    dm_addr   = '0;
    dm_wd     = '0;
    p0_ack    = 1'b0;
    p0_rd     = '0;
    p0_err    = 1'b0;
    p1_ack    = 1'b0;
    p1_rd     = '0;
    p1_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          port_d  = gnt[1];
          req_d   = gnt[1] ? '{p1_we, p1_width, p1_sign, p1_addr, p1_wd}
                           : '{p0_we, p0_width, p0_sign, p0_addr, p0_wd};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A rejected store must never reach the memory write enable.
        dm_we     = req_q.we & ~err_now;
        dm_width  = req_q.width;
        dm_sign   = req_q.sign;
        dm_addr   = req_q.addr;
        dm_wd     = req_q.wd;
        rsp_rd_d  = err_now ? '0 : dm_rd;
        rsp_err_d = err_now;
        state_d   = RESP;
      end
      RESP: begin
        if (port_q) begin
          p1_ack = 1'b1;
          p1_rd  = rsp_rd_q;
          p1_err = rsp_err_q;
        end else begin
          p0_ack = 1'b1;
          p0_rd  = rsp_rd_q;
          p0_err = rsp_err_q;
        end
        ptr_d   = ~port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      ptr_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      ptr_q     <= ptr_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Request fields and read data are only observed behind state gating.
  always_ff @(posedge clk) begin
    req_q    <= req_d;
    rsp_rd_q <= rsp_rd_d;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level reference model with a shadow
// memory, a per-cycle compare process, and directed scenarios.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam bit MAIN_FP = 1'b0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p0_sign, p0_ack, p0_err;
  logic [1:0]  p0_width;
  logic [31:0] p0_addr, p0_wd, p0_rd;
  logic        p1_req, p1_we, p1_sign, p1_ack, p1_err;
  logic [1:0]  p1_width;
  logic [31:0] p1_addr, p1_wd, p1_rd;
  logic        dm_we, dm_sign;
  logic [1:0]  dm_width;
  logic [31:0] dm_addr, dm_wd, dm_rd;

  logic        f0_req, f1_req, f0_ack, f1_ack, f0_err, f1_err;
  logic [31:0] f0_addr, f1_addr, f0_rd, f1_rd;
  logic        f_dm_we, f_dm_sign;
  logic [1:0]  f_dm_width;
  logic [31:0] f_dm_addr, f_dm_wd, f_dm_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_total = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dm_we) we_total <= we_total + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dm_read(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [1:0] wid, input logic s);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? w[31:16] : w[15:0];
    b = 8'(w >> (8 * int'(lo)));
    case (wid)
      HALF:    return s ? {{16{h[15]}}, h} : {16'h0, h};
      BYTE:    return s ? {{24{b[7]}}, b} : {24'h0, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dm_merge(input logic [31:0] old, input logic [1:0] lo,
                                           input logic [1:0] wid, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (wid)
      HALF:    if (lo[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      BYTE:    r[8*int'(lo) +: 8] = d[7:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit bad_access(input logic [1:0] wid, input logic [31:0] a);
`ifdef DM_ARB_ALIGN_CHECK_EN
    return (wid == 2'b11) || (wid == WORD && a[1:0] != 2'b00) || (wid == HALF && a[0]);
`else
    return (wid == 2'b11 && a[0] && !a[0]);
`endif
  endfunction

  // Data memory environment, with a preload path used during reset.
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:63] = '{default: 32'h0};
  assign dm_rd = dm_read(mem[dm_addr[7:2]], dm_addr[1:0], dm_width, dm_sign);
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (dm_we) mem[dm_addr[7:2]] <= dm_merge(mem[dm_addr[7:2]], dm_addr[1:0], dm_width, dm_wd);
  end

  assign f_dm_rd = f_dm_addr ^ 32'hA5A5_0000;

  dm_arbiter #(.FIXED_PRI(0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_width(p0_width), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wd(p0_wd), .p0_ack(p0_ack), .p0_rd(p0_rd), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_width(p1_width), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wd(p1_wd), .p1_ack(p1_ack), .p1_rd(p1_rd), .p1_err(p1_err),
    .dm_we(dm_we), .dm_width(dm_width), .dm_sign(dm_sign), .dm_addr(dm_addr),
    .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  dm_arbiter #(.FIXED_PRI(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(f0_req), .p0_we(1'b0), .p0_width(WORD), .p0_sign(1'b0),
    .p0_addr(f0_addr), .p0_wd(32'h0), .p0_ack(f0_ack), .p0_rd(f0_rd), .p0_err(f0_err),
    .p1_req(f1_req), .p1_we(1'b0), .p1_width(WORD), .p1_sign(1'b0),
    .p1_addr(f1_addr), .p1_wd(32'h0), .p1_ack(f1_ack), .p1_rd(f1_rd), .p1_err(f1_err),
    .dm_we(f_dm_we), .dm_width(f_dm_width), .dm_sign(f_dm_sign), .dm_addr(f_dm_addr),
    .dm_wd(f_dm_wd), .dm_rd(f_dm_rd)
  );

  // Reference model: a granted transaction occupies the memory in the cycle
  // after the grant and is acknowledged in the cycle after that.
  int          m_phase = 0;
  bit          m_port = 1'b0, m_ptr = 1'b0, m_err = 1'b0;
  dm_req_t     m_t = '0;
  logic [31:0] m_rd = '0;
  logic [31:0] shadow [0:63] = '{default: 32'h0};

  always @(posedge clk or negedge reset) begin
    if (pre_we && clk) shadow[pre_idx] = pre_data;
    if (!reset) begin
      m_phase = 0;
      m_ptr   = 1'b0;
    end else if (m_phase == 0) begin
      if (p0_req || p1_req) begin
        m_port  = (p0_req && p1_req) ? (MAIN_FP ? 1'b0 : m_ptr) : p1_req;
        m_t     = m_port ? '{p1_we, p1_width, p1_sign, p1_addr, p1_wd}
                         : '{p0_we, p0_width, p0_sign, p0_addr, p0_wd};
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_err = bad_access(m_t.width, m_t.addr);
      m_rd  = m_err ? 32'h0 : dm_read(shadow[m_t.addr[7:2]], m_t.addr[1:0], m_t.width, m_t.sign);
      if (m_t.we && !m_err)
        shadow[m_t.addr[7:2]] = dm_merge(shadow[m_t.addr[7:2]], m_t.addr[1:0], m_t.width, m_t.wd);
      m_phase = 2;
    end else begin
      m_ptr   = !m_port;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      bit acc, rsp;
      acc = (m_phase == 1);
      rsp = (m_phase == 2);
      check("dm_we", 32'(dm_we), 32'(acc && m_t.we && !bad_access(m_t.width, m_t.addr)));
      check("dm_addr", dm_addr, acc ? m_t.addr : 32'h0);
      check("dm_wd", dm_wd, acc ? m_t.wd : 32'h0);
      check("dm_ctl", {29'h0, dm_width, dm_sign}, acc ? {29'h0, m_t.width, m_t.sign} : 32'h0);
      check("p0_ack", 32'(p0_ack), 32'(rsp && !m_port));
      check("p1_ack", 32'(p1_ack), 32'(rsp && m_port));
      check("p0_rd", p0_rd, (rsp && !m_port) ? m_rd : 32'h0);
      check("p1_rd", p1_rd, (rsp && m_port) ? m_rd : 32'h0);
      check("p0_err", 32'(p0_err), 32'(rsp && !m_port && m_err));
      check("p1_err", 32'(p1_err), 32'(rsp && m_port && m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit rq, input bit we, input logic [1:0] w,
                       input bit s, input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      p1_req = rq; p1_we = we; p1_width = w; p1_sign = s; p1_addr = a; p1_wd = d;
    end else begin
      p0_req = rq; p0_we = we; p0_width = w; p0_sign = s; p0_addr = a; p0_wd = d;
    end
  endtask

  // One complete handshake; call at posedge+#1. lat counts cycles from req to ack.
  task automatic xfer(input bit port, input bit we, input logic [1:0] w, input bit s,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit err, output int lat);
    int  start;
    bit  got;
    got = 1'b0; rd = '0; err = 1'b0; lat = -1;
    drive(port, 1'b1, we, w, s, a, d);
    start = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin
        got = 1'b1;
        rd  = port ? p1_rd : p0_rd;
        err = port ? p1_err : p0_err;
        lat = cyc - start;
      end
    end
    if (!got) check("ack_timeout", 32'h0, 32'h1);
    tick();
    drive(port, 1'b0, 1'b0, WORD, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] rd;
  bit          err;
  int          lat, w0, n, last_f0, f0_cnt, f1_cnt;
  int          ord [0:3];
  int          at  [0:3];
  bit          found;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, WORD, 0, 0, 0);
    drive(1, 0, 0, WORD, 0, 0, 0);
    f0_req = 1'b0; f1_req = 1'b0; f0_addr = 32'h100; f1_addr = 32'h204;
    tick();
    pre_we = 1'b1; pre_idx = 6'd8; pre_data = 32'h0000_80FF;
    tick();
    pre_we = 1'b0;
    @(negedge clk);
    check("rst_dm_we", 32'(dm_we), 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wd", dm_wd, 32'h0);
    check("rst_acks", {28'h0, p0_ack, p1_ack, p0_err, p1_err}, 32'h0);
    check("rst_rds", p0_rd | p1_rd, 32'h0);
    reset = 1'b1;
    tick();

    // Word store then load back through port 0.
    w0 = we_total;
    xfer(0, 1, WORD, 0, 32'h10, 32'h1234_5678, rd, err, lat);
    check("store_lat", lat, 2);
    check("store_we_cycles", we_total - w0, 1);
    check("store_mem", mem[4], 32'h1234_5678);
    xfer(0, 0, WORD, 0, 32'h10, 32'h0, rd, err, lat);
    check("load_word", rd, 32'h1234_5678);

    // Sub-word loads through port 1.
    xfer(1, 0, BYTE, 1, 32'h21, 32'h0, rd, err, lat);
    check("byte_sext", rd, 32'hFFFF_FF80);
    xfer(1, 0, BYTE, 0, 32'h21, 32'h0, rd, err, lat);
    check("byte_zext", rd, 32'h0000_0080);
    xfer(1, 0, HALF, 1, 32'h20, 32'h0, rd, err, lat);
    check("half_sext", rd, 32'hFFFF_80FF);

`ifdef DM_ARB_ALIGN_CHECK_EN
    w0 = we_total;
    xfer(0, 1, WORD, 0, 32'h13, 32'hDEAD_BEEF, rd, err, lat);
    check("mis_store_err", 32'(err), 32'h1);
    check("mis_store_rd", rd, 32'h0);
    check("mis_store_we", we_total - w0, 0);
    check("mis_store_mem", mem[4], 32'h1234_5678);
    xfer(1, 0, 2'b11, 0, 32'h20, 32'h0, rd, err, lat);
    check("w11_err", 32'(err), 32'h1);
`else
    xfer(0, 0, WORD, 0, 32'h13, 32'h0, rd, err, lat);
    check("unal_load_err", 32'(err), 32'h0);
    check("unal_load_rd", rd, 32'h1234_5678);
`endif

    // Continuous simultaneous requests after reset alternate p0, p1.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    tick();
    drive(0, 1, 0, WORD, 0, 32'h10, 32'h0);
    drive(1, 1, 0, WORD, 0, 32'h20, 32'h0);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (p0_ack) begin ord[n] = 0; at[n] = cyc; n++; end
      else if (p1_ack) begin ord[n] = 1; at[n] = cyc; n++; end
    end
    tick();
    drive(0, 0, 0, WORD, 0, 0, 0);
    drive(1, 0, 0, WORD, 0, 0, 0);
    check("rr_count", n, 4);
    if (n == 4) begin
      check("rr_order", {ord[0][7:0], ord[1][7:0], ord[2][7:0], ord[3][7:0]}, 32'h0001_0001);
      check("rr_gap1", at[1] - at[0], 3);
      check("rr_gap3", at[3] - at[2], 3);
    end
    tick();

    // Reset in the ACCESS cycle of a p1 store.
    drive(1, 1, 1, WORD, 0, 32'h30, 32'hCAFE_F00D);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dm_we) found = 1'b1;
    end
    check("abort_we_seen", 32'(found), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_we_async", 32'(dm_we), 32'h0);
    check("abort_addr_async", dm_addr, 32'h0);
    drive(1, 0, 0, WORD, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (p1_ack) n++;
    end
    check("abort_no_ack", n, 0);
    check("abort_mem", mem[12], 32'h0);
    tick();
    drive(0, 1, 0, WORD, 0, 32'h10, 32'h0);
    drive(1, 1, 0, WORD, 0, 32'h20, 32'h0);
    n = -1;
    for (int i = 0; i < 10 && n < 0; i++) begin
      @(negedge clk);
      if (p0_ack) n = 0;
      else if (p1_ack) n = 1;
    end
    check("abort_ptr_p0", n, 0);
    tick();
    drive(0, 0, 0, WORD, 0, 0, 0);
    drive(1, 0, 0, WORD, 0, 0, 0);
    tick();

    // Fixed priority: p1 starves while p0 keeps requesting.
    f0_req = 1'b1; f1_req = 1'b1;
    f0_cnt = 0; f1_cnt = 0; last_f0 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f0_ack) begin f0_cnt++; last_f0 = cyc; end
      if (f1_ack) f1_cnt++;
    end
    check("fp_p0_acks", f0_cnt, 4);
    check("fp_p1_acks", f1_cnt, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (f0_ack) begin found = 1'b1; last_f0 = cyc; check("fp_p0_rd", f0_rd, 32'hA5A5_0100); end
    end
    check("fp_p0_ack_seen", 32'(found), 32'h1);
    tick();
    f0_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (f1_ack) begin
        found = 1'b1;
        check("fp_p1_gap", cyc - last_f0, 3);
        check("fp_p1_rd", f1_rd, 32'hA5A5_0204);
        check("fp_p1_err", 32'(f1_err | f0_err), 32'h0);
      end
    end
    check("fp_p1_ack_seen", 32'(found), 32'h1);
    tick();
    f1_req = 1'b0;
    tick();
    @(negedge clk);
    check("fp_idle_dm", {f_dm_we, f_dm_width, f_dm_sign} | f_dm_wd | f_dm_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
